cia_eclk_arbiter: RTL and testbench
===================================

# cia_eclk_arbiter

Two-requester arbiter and E-clock bus-cycle sequencer for the CIA peripheral bus. Grants one of two requesters (A: CPU bridge, B: host/debug bridge), aligns the access to the 10-phase one-hot E-clock from the clock generator, and drives the CIA select/strobe signals. Completes the access with a one-cycle acknowledge and, for reads, the captured data. Sits between the bus bridges and the two CIA instances in the clk_28 domain.

## Interface
Parameters: none.

- clk_28  in  1  system clock, 28.375 MHz; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- clk7_en  in  1  7 MHz clock enable; the FSM advances only on edges where clk7_en=1
- eclk  in  10  one-hot E-clock phase; advances once per 7 MHz cycle
- req_a / req_b  in  1  access request, level, held until ack
- rw_a / rw_b  in  1  1=read, 0=write
- addr_a / addr_b  in  5  [4]=CIA B select, [3:0]=register select
- wdata_a / wdata_b  in  8  write data
- ack_a / ack_b  out  1  one-clk_28 completion pulse
- rdata  out  8  read data, valid from ack, held until next read completes
- cia_cs_n  out  2  [0]=CIA A, [1]=CIA B chip select, active low
- cia_rs  out  4  register select
- cia_rw  out  1  1=read
- cia_wdata  out  8  write data
- cia_rdata  in  8  CIA read data
- cia_e  out  1  registered E level to CIAs

## Operation
- Phase p = index of lowest set bit of eclk, sampled on clk7_en edges. eclk=0: no phase; FSM holds state (no advance, no grant).
- States IDLE, WAIT, SETUP, EHIGH. All transitions on clk7_en edges only.
- IDLE: if any req: grant; if both, grant the requester not granted last (last_grant reset = B, so A wins first contention). Latch rw/addr/wdata into cia_rw/cia_rs/cia_wdata; -> WAIT.
- WAIT: at edge with p=2: assert cia_cs_n[addr[4]]=0, other bit 1; -> SETUP. Otherwise hold.
- SETUP: at edge with p=5 -> EHIGH.
- EHIGH: at edge with p=9: if read, rdata <= cia_rdata; pulse ack of granted requester; cia_cs_n <= 2'b11; update last_grant; -> IDLE.
- cia_e <= (p in 5..8) on every clk7_en edge: E high during phases 6..9.
- cia_rw/cia_rs/cia_wdata hold their latched values until the next grant.
- No abort: a dropped req before ack is ignored; the cycle still completes and acks.

## Timing
- Reset values: ack_a=ack_b=0, rdata=0, cia_cs_n=2'b11, cia_rs=0, cia_rw=1, cia_wdata=0, cia_e=0; state IDLE, last_grant=B.
- Reset mid-access: asynchronous clear to the above; no ack issued; the requester must re-issue.
- ack is high exactly one clk_28 cycle (the cycle after the p=9 clk7_en edge).
- Requester must drop req before the next clk7_en edge, 4 clk_28 after ack. A req still high then is a new request.
- Latency, grant edge to ack edge, in clk7 cycles: grant at p=0 -> 9; p=1 -> 8; p=2..9 -> complete in the next E period, p=2 -> 17 (maximum).
- Chip select is low from the p=2 edge to the p=9 edge: 7 clk7 cycles, 28 clk_28.
- Back-to-back: a grant in IDLE at the edge after ack (p=0) completes in the following period, so a saturated bus gives one access per E period. Contention alternates A, B, A, ...
- Simultaneous new req and ack for the other requester: the new req is considered at the next IDLE edge, with normal fairness.

## Test plan
- Single read A, addr=5'h0D, grant at p=0, cia_rdata=8'h5A -> cia_cs_n=2'b10 from the p=2 edge; ack_a one cycle after the p=9 edge (36 clk_28 after grant); rdata=8'h5A.
- Write B, addr=5'h13, wdata=8'hC3, grant at p=2 -> cia_cs_n=2'b01, cia_rw=0, cia_wdata=8'hC3; ack_b 17 clk7 cycles after grant.
- req_a and req_b held continuously -> acks alternate A, B, A, B starting with A; exactly one ack per 10 clk7 cycles.
- Assert reset_n=0 in EHIGH -> all outputs take reset values immediately; no ack; after release, a held req restarts from IDLE.
- Hold eclk=0 for 20 clk7 cycles in WAIT -> state and outputs frozen; resume one-hot -> the cycle completes normally.
- Drop req_a after ack, then re-raise 2 clk_28 later -> treated as a new request at the next clk7_en; second ack one E period later.

Source files
------------

// File: rtl/cia_eclk_arbiter.sv
// rtl/cia_eclk_arbiter.sv - two-requester arbiter and E-clock bus-cycle sequencer for the CIA bus
//
// Grants requester A (CPU bridge) or B (host/debug bridge), aligns the access
// to the one-hot E-clock phase and drives the CIA select/strobe outputs.
//
// Ports:
//   clk_28, reset_n         system clock, asynchronous active-low reset
//   clk7_en                 7 MHz enable; the sequencer only moves on these edges
//   eclk[9:0]               one-hot E-clock phase from the clock generator
//   req/rw/addr/wdata _a/_b requester side (level request, held until ack)
//   ack_a, ack_b            one-cycle completion pulses
//   rdata                   last read data, valid from ack
//   cia_cs_n, cia_rs, cia_rw, cia_wdata, cia_e   CIA bus outputs
//   cia_rdata               CIA read data
module cia_eclk_arbiter (
  input  logic       clk_28,
  input  logic       reset_n,
  input  logic       clk7_en,
  input  logic [9:0] eclk,
  input  logic       req_a,
  input  logic       req_b,
  input  logic       rw_a,
  input  logic       rw_b,
  input  logic [4:0] addr_a,
  input  logic [4:0] addr_b,
  input  logic [7:0] wdata_a,
  input  logic [7:0] wdata_b,
  output logic       ack_a,
  output logic       ack_b,
  output logic [7:0] rdata,
  output logic [1:0] cia_cs_n,
  output logic [3:0] cia_rs,
  output logic       cia_rw,
  output logic [7:0] cia_wdata,
  input  logic [7:0] cia_rdata,
  output logic       cia_e
);

  typedef enum logic [1:0] {IDLE, WAIT, SETUP, EHIGH} state_t;

  state_t     state;
  logic       gnt_b;      // requester owning the current access
  logic       last_b;     // last completed access went to B
  logic       sel_cia_b;  // latched addr[4] of the current access
  logic [3:0] ph;
  logic       ph_valid;
  logic       pick_b;

  // Lowest set bit of eclk wins, so a malformed multi-hot value still
  // resolves to a single phase.
  always_comb begin
    ph = 4'd0;
    for (int i = 9; i >= 0; i--) begin
      if (eclk[i]) ph = i[3:0];
    end
  end

  assign ph_valid = |eclk;

  // Under contention the requester that did not win last time is chosen.
  assign pick_b = req_b && (!req_a || !last_b);

  always_ff @(posedge clk_28 or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      gnt_b     <= 1'b0;
      last_b    <= 1'b1;
      sel_cia_b <= 1'b0;
      ack_a     <= 1'b0;
      ack_b     <= 1'b0;
      rdata     <= 8'h00;
      cia_cs_n  <= 2'b11;
      cia_rs    <= 4'h0;
      cia_rw    <= 1'b1;
      cia_wdata <= 8'h00;
      cia_e     <= 1'b0;
    end else begin
      ack_a <= 1'b0;
      ack_b <= 1'b0;
      if (clk7_en && ph_valid) begin
        // E is registered, so it rises one phase after the p=5 edge.
        cia_e <= (ph >= 4'd5) && (ph <= 4'd8);
        case (state)
          IDLE: begin
            if (req_a || req_b) begin
              gnt_b     <= pick_b;
              cia_rw    <= pick_b ? rw_b : rw_a;
              cia_rs    <= pick_b ? addr_b[3:0] : addr_a[3:0];
              sel_cia_b <= pick_b ? addr_b[4] : addr_a[4];
              cia_wdata <= pick_b ? wdata_b : wdata_a;
              state     <= WAIT;
            end
          end
          WAIT: begin
            if (ph == 4'd2) begin
              cia_cs_n <= sel_cia_b ? 2'b01 : 2'b10;
              state    <= SETUP;
            end
          end
          SETUP: begin
            if (ph == 4'd5) state <= EHIGH;
          end
          EHIGH: begin
            if (ph == 4'd9) begin
              if (cia_rw) rdata <= cia_rdata;
              ack_a    <= !gnt_b;
              ack_b    <= gnt_b;
              cia_cs_n <= 2'b11;
              last_b   <= gnt_b;
              state    <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cia_eclk_arbiter.sv
// tb/tb_cia_eclk_arbiter.sv - directed self-checking bench for cia_eclk_arbiter
module tb_cia_eclk_arbiter;

  logic       clk_28 = 1'b0;
  logic       reset_n = 1'b0;
  logic       clk7_en = 1'b0;
  logic [9:0] eclk = 10'd0;
  logic       req_a = 1'b0, req_b = 1'b0;
  logic       rw_a = 1'b1, rw_b = 1'b1;
  logic [4:0] addr_a = 5'd0, addr_b = 5'd0;
  logic [7:0] wdata_a = 8'd0, wdata_b = 8'd0;
  logic       ack_a, ack_b;
  logic [7:0] rdata;
  logic [1:0] cia_cs_n;
  logic [3:0] cia_rs;
  logic       cia_rw;
  logic [7:0] cia_wdata;
  logic [7:0] cia_rdata = 8'h00;
  logic       cia_e;

  int checks = 0;
  int fails  = 0;

  int   ph_cnt = 0;
  int   div = 0;
  logic freeze = 1'b0;

  cia_eclk_arbiter dut (
    .clk_28(clk_28), .reset_n(reset_n), .clk7_en(clk7_en), .eclk(eclk),
    .req_a(req_a), .req_b(req_b), .rw_a(rw_a), .rw_b(rw_b),
    .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
    .ack_a(ack_a), .ack_b(ack_b), .rdata(rdata),
    .cia_cs_n(cia_cs_n), .cia_rs(cia_rs), .cia_rw(cia_rw),
    .cia_wdata(cia_wdata), .cia_rdata(cia_rdata), .cia_e(cia_e)
  );

  always #5 clk_28 = ~clk_28;

  // Clock generator model: 7 MHz enable every 4th clk_28, phase advances per enable.
  always @(negedge clk_28) begin
    if (clk7_en) ph_cnt = (ph_cnt == 9) ? 0 : ph_cnt + 1;
    div     = (div == 3) ? 0 : div + 1;
    clk7_en = (div == 0);
    eclk    = freeze ? 10'd0 : (10'd1 << ph_cnt);
  end

  // Leaves time just before a clk7_en edge whose phase is p.
  task automatic goto_phase(input int p);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_28); #1;
      if (clk7_en && eclk == (10'd1 << p)) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      fails++;
      $display("FAIL goto_phase: phase %0d not reached, found=%0b required 1", p, found);
    end
  endtask

  task automatic test_reset;
    checks++;
    if ({ack_a, ack_b, rdata, cia_cs_n, cia_rs, cia_rw, cia_wdata, cia_e} !==
        {1'b0, 1'b0, 8'h00, 2'b11, 4'h0, 1'b1, 8'h00, 1'b0}) begin
      fails++;
      $display("FAIL reset_values: ack=%b%b rdata=%h cs=%b rs=%h rw=%b wd=%h e=%b required 00 00 11 0 1 00 0",
               ack_a, ack_b, rdata, cia_cs_n, cia_rs, cia_rw, cia_wdata, cia_e);
    end
  endtask

  task automatic test_read_a;
    int k;
    logic got, stray;
    goto_phase(0);
    rw_a = 1'b1; addr_a = 5'h0D; cia_rdata = 8'h5A; req_a = 1'b1;
    @(posedge clk_28);
    k = 0; got = 1'b0; stray = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk_28); #1;
      k = i;
      if (ack_b) stray = 1'b1;
      if (i == 1) begin
        checks++;
        if (cia_rw !== 1'b1 || cia_rs !== 4'hD || cia_cs_n !== 2'b11) begin
          fails++;
          $display("FAIL read_a_latch: rw=%b rs=%h cs=%b required 1 d 11", cia_rw, cia_rs, cia_cs_n);
        end
      end
      if (i == 7) begin
        checks++;
        if (cia_cs_n !== 2'b11) begin
          fails++; $display("FAIL read_a_cs_before: cs=%b required 11", cia_cs_n);
        end
      end
      if (i == 8) begin
        checks++;
        if (cia_cs_n !== 2'b10) begin
          fails++; $display("FAIL read_a_cs_p2: cs=%b required 10", cia_cs_n);
        end
      end
      if (i == 19) begin
        checks++;
        if (cia_e !== 1'b0) begin
          fails++; $display("FAIL read_a_e_low: e=%b required 0", cia_e);
        end
      end
      if (i == 20) begin
        checks++;
        if (cia_e !== 1'b1) begin
          fails++; $display("FAIL read_a_e_high: e=%b required 1", cia_e);
        end
      end
      if (ack_a) begin got = 1'b1; break; end
    end
    req_a = 1'b0;
    checks++;
    if (!got || k != 36) begin
      fails++; $display("FAIL read_a_latency: got=%0b k=%0d required 36", got, k);
    end
    checks++;
    if (rdata !== 8'h5A || cia_cs_n !== 2'b11 || stray) begin
      fails++; $display("FAIL read_a_done: rdata=%h cs=%b stray_b=%b required 5a 11 0", rdata, cia_cs_n, stray);
    end
    @(posedge clk_28); #1;
    checks++;
    if (ack_a !== 1'b0) begin
      fails++; $display("FAIL read_a_ack_width: ack_a=%b required 0", ack_a);
    end
  endtask

  task automatic test_write_b;
    int k;
    logic got;
    goto_phase(2);
    rw_b = 1'b0; addr_b = 5'h13; wdata_b = 8'hC3; req_b = 1'b1;
    @(posedge clk_28);
    k = 0; got = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk_28); #1;
      k = i;
      if (i == 1) begin
        checks++;
        if (cia_rw !== 1'b0 || cia_wdata !== 8'hC3 || cia_rs !== 4'h3 || cia_cs_n !== 2'b11) begin
          fails++;
          $display("FAIL write_b_latch: rw=%b wd=%h rs=%h cs=%b required 0 c3 3 11", cia_rw, cia_wdata, cia_rs, cia_cs_n);
        end
      end
      if (i == 39) begin
        checks++;
        if (cia_cs_n !== 2'b11) begin
          fails++; $display("FAIL write_b_cs_before: cs=%b required 11", cia_cs_n);
        end
      end
      if (i == 40) begin
        checks++;
        if (cia_cs_n !== 2'b01) begin
          fails++; $display("FAIL write_b_cs: cs=%b required 01", cia_cs_n);
        end
      end
      if (ack_b) begin got = 1'b1; break; end
    end
    req_b = 1'b0;
    checks++;
    if (!got || k != 68) begin
      fails++; $display("FAIL write_b_latency: got=%0b k=%0d required 68", got, k);
    end
    checks++;
    if (rdata !== 8'h5A) begin
      fails++; $display("FAIL write_b_rdata_held: rdata=%h required 5a", rdata);
    end
  endtask

  task automatic test_contention;
    int   n;
    logic who [4];
    int   when [4];
    logic both;
    goto_phase(0);
    rw_a = 1'b1; rw_b = 1'b1; addr_a = 5'h01; addr_b = 5'h11;
    req_a = 1'b1; req_b = 1'b1;
    @(posedge clk_28);
    n = 0; both = 1'b0;
    for (int i = 1; i <= 200 && n < 4; i++) begin
      @(posedge clk_28); #1;
      if (ack_a && ack_b) both = 1'b1;
      if (ack_a || ack_b) begin
        who[n]  = ack_b;
        when[n] = i;
        n++;
      end
    end
    req_a = 1'b0; req_b = 1'b0;
    checks++;
    if (n != 4 || both) begin
      fails++; $display("FAIL contention_count: acks=%0d both=%0b required 4 0", n, both);
    end else begin
      checks++;
      if ({who[0], who[1], who[2], who[3]} !== 4'b0101) begin
        fails++; $display("FAIL contention_order: order(B=1)=%b%b%b%b required 0101", who[0], who[1], who[2], who[3]);
      end
      checks++;
      if (when[0] != 36 || when[1] != 76 || when[2] != 116 || when[3] != 156) begin
        fails++; $display("FAIL contention_timing: %0d %0d %0d %0d required 36 76 116 156", when[0], when[1], when[2], when[3]);
      end
    end
    repeat (8) @(posedge clk_28);
  endtask

  task automatic test_reset_mid;
    logic saw, got, saw_cs;
    goto_phase(0);
    rw_a = 1'b1; addr_a = 5'h1F; cia_rdata = 8'h5A; req_a = 1'b1;
    @(posedge clk_28);
    repeat (22) @(posedge clk_28);
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({ack_a, ack_b, rdata, cia_cs_n, cia_rs, cia_rw, cia_wdata, cia_e} !==
        {1'b0, 1'b0, 8'h00, 2'b11, 4'h0, 1'b1, 8'h00, 1'b0}) begin
      fails++;
      $display("FAIL reset_mid_values: ack=%b%b rdata=%h cs=%b rs=%h rw=%b wd=%h e=%b required 00 00 11 0 1 00 0",
               ack_a, ack_b, rdata, cia_cs_n, cia_rs, cia_rw, cia_wdata, cia_e);
    end
    saw = 1'b0;
    repeat (20) begin
      @(posedge clk_28); #1;
      if (ack_a || ack_b || cia_cs_n !== 2'b11) saw = 1'b1;
    end
    checks++;
    if (saw) begin
      fails++; $display("FAIL reset_mid_quiet: activity=%b required 0", saw);
    end
    @(negedge clk_28);
    reset_n = 1'b1;
    got = 1'b0; saw_cs = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk_28); #1;
      if (cia_cs_n === 2'b01) saw_cs = 1'b1;
      if (ack_a) begin got = 1'b1; break; end
    end
    req_a = 1'b0;
    checks++;
    if (!got || !saw_cs || rdata !== 8'h5A) begin
      fails++; $display("FAIL reset_mid_restart: ack=%b cs_seen=%b rdata=%h required 1 1 5a", got, saw_cs, rdata);
    end
  endtask

  task automatic test_freeze;
    logic moved, got, saw_cs;
    goto_phase(0);
    rw_b = 1'b1; addr_b = 5'h02; cia_rdata = 8'h96; req_b = 1'b1;
    @(posedge clk_28);
    @(posedge clk_28); #1;
    freeze = 1'b1;
    moved = 1'b0;
    repeat (80) begin
      @(posedge clk_28); #1;
      if (cia_cs_n !== 2'b11 || ack_b || ack_a || cia_e !== 1'b0) moved = 1'b1;
    end
    checks++;
    if (moved) begin
      fails++; $display("FAIL freeze_hold: changed=%b required 0", moved);
    end
    freeze = 1'b0;
    got = 1'b0; saw_cs = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk_28); #1;
      if (cia_cs_n === 2'b10) saw_cs = 1'b1;
      if (ack_b) begin got = 1'b1; break; end
    end
    req_b = 1'b0;
    checks++;
    if (!got || !saw_cs || rdata !== 8'h96) begin
      fails++; $display("FAIL freeze_resume: ack=%b cs_seen=%b rdata=%h required 1 1 96", got, saw_cs, rdata);
    end
  endtask

  task automatic test_back_to_back;
    int k, j;
    logic got;
    goto_phase(0);
    rw_a = 1'b0; addr_a = 5'h04; wdata_a = 8'h11; req_a = 1'b1;
    @(posedge clk_28);
    k = 0; got = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk_28); #1;
      k = i;
      if (ack_a) begin got = 1'b1; break; end
    end
    req_a = 1'b0;
    checks++;
    if (!got || k != 36) begin
      fails++; $display("FAIL b2b_first: got=%0b k=%0d required 36", got, k);
    end
    @(posedge clk_28); #1;
    checks++;
    if (ack_a !== 1'b0) begin
      fails++; $display("FAIL b2b_ack_width: ack_a=%b required 0", ack_a);
    end
    @(posedge clk_28); #1;
    req_a = 1'b1;
    j = 0; got = 1'b0;
    for (int i = 39; i <= 140; i++) begin
      @(posedge clk_28); #1;
      j = i;
      if (ack_a) begin got = 1'b1; break; end
    end
    req_a = 1'b0;
    checks++;
    if (!got || j != 76) begin
      fails++; $display("FAIL b2b_second: got=%0b k=%0d required 76", got, j);
    end
  endtask

  initial begin
    repeat (5) @(posedge clk_28);
    #1;
    test_reset;
    @(negedge clk_28);
    reset_n = 1'b1;
    test_read_a;
    test_write_b;
    test_contention;
    test_reset_mid;
    test_freeze;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
